mem_io_responder: RTL and testbench

- Target side of the byte-wide memory bus driven by the memory controller (mem_a, mem_wr, mem_dout in; mem_din, io_buffer_full out).
- Provides unified byte-addressed RAM plus a memory-mapped UART window at 0x30000-0x30007.
- Buffers outgoing UART bytes in a TX FIFO, incoming bytes optionally in an RX FIFO, and raises io_buffer_full for backpressure.
- Serves as the RAM/IO model in simulation and as the on-chip RAM/IO block in FPGA builds.

---
 rtl/mem_io_responder_pkg.sv | 20 ++
 rtl/mem_io_responder_byte_fifo.sv | 54 +++++
 rtl/mem_io_responder.sv | 141 ++++++++++++++
 tb/tb_mem_io_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the memory/IO responder: UART window addresses,
// the IO decode mask and the bit positions of the UART status byte.
// Optional feature macro: MEMRESP_RX_EN (enables the RX FIFO path).
package mem_io_responder_pkg;

    localparam logic [17:0] IO_BASE        = 18'h30000;
    localparam logic [17:0] IO_UART_DATA   = 18'h30000;
    localparam logic [17:0] IO_UART_STAT   = 18'h30004;
    localparam logic [17:0] IO_DECODE_MASK = 18'h30000;

    // Bit positions inside the byte returned by a read of IO_UART_STAT.
    localparam int STAT_TX_FULL     = 0;
    localparam int STAT_RX_NONEMPTY = 1;

    // Any address whose two top decoded bits are set lands in the IO window.
    function automatic logic is_io(input logic [17:0] addr);
        return (addr & IO_DECODE_MASK) == IO_BASE;
    endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// byte_fifo: single-clock byte FIFO with registered count.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; callers qualify push/pop with any global enable before driving them.
module byte_fifo #(
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next,
    output logic          full,
    output logic          empty
);

    logic [7:0]    storage [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign pop_ok     = pop && !empty;
    assign push_ok    = push && (!full || pop_ok);
    assign count_next = count + CW'(push_ok) - CW'(pop_ok);
    assign dout       = storage[rd_ptr];

    // Data storage: written on accepted pushes only.
    // NOTE: storage carries no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) storage[wr_ptr] <= din;
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-wide RAM plus UART window (0x30000-0x30007) on the
// memory controller bus. Reads have one cycle of latency through mem_din.
// Optional feature macro: MEMRESP_RX_EN (RX FIFO, pops on reads of 0x30000).
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 8,
    parameter int RX_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        halt
);

    localparam int TX_CW = $clog2(TX_DEPTH) + 1;

    logic [7:0]            ram [2**ADDR_WIDTH];
    logic [17:0]           dec_addr;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  io;
    logic                  tx_push;
    logic                  tx_pop;
    logic                  tx_full;
    logic                  tx_empty;
    logic [TX_CW-1:0]      tx_count;
    logic [TX_CW-1:0]      tx_count_next;
    logic                  tx_overflow;
    logic [7:0]            rx_head;
    logic                  rx_nonempty;
    logic [7:0]            io_rdata;
    logic                  unused_ok;

    assign dec_addr = mem_a[17:0];
    assign ram_addr = mem_a[ADDR_WIDTH-1:0];
    assign io       = is_io(dec_addr);

    // UART side is free-running, so pops ignore rdy; bus pushes do not.
    assign tx_push  = rdy && io && mem_wr && (dec_addr == IO_UART_DATA);
    assign tx_pop   = tx_valid && tx_ready;
    assign tx_valid = !tx_empty;

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (tx_push),
        .pop        (tx_pop),
        .din        (mem_dout),
        .dout       (tx_data),
        .count      (tx_count),
        .count_next (tx_count_next),
        .full       (tx_full),
        .empty      (tx_empty)
    );

`ifdef MEMRESP_RX_EN
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;

    logic             rx_pop;
    logic [7:0]       rx_dout;
    logic [RX_CW-1:0] rx_count;
    logic [RX_CW-1:0] rx_count_next;
    logic             rx_full;
    logic             rx_empty;

    assign rx_pop      = rdy && io && !mem_wr && (dec_addr == IO_UART_DATA);
    assign rx_nonempty = !rx_empty;
    assign rx_head     = rx_empty ? 8'h00 : rx_dout;

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (rdy && rx_valid),
        .pop        (rx_pop),
        .din        (rx_data),
        .dout       (rx_dout),
        .count      (rx_count),
        .count_next (rx_count_next),
        .full       (rx_full),
        .empty      (rx_empty)
    );

    assign unused_ok = ^{mem_a[31:18], tx_overflow, tx_count, rx_count, rx_count_next, rx_full};
`else
    assign rx_nonempty = 1'b0;
    assign rx_head     = 8'h00;
    assign unused_ok   = ^{mem_a[31:18], tx_overflow, tx_count, rx_data, rx_valid, RX_DEPTH[0]};
`endif

    // IO read data mux for the UART window.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        io_rdata = 8'h00;
        if (dec_addr == IO_UART_DATA) begin
            io_rdata = rx_head;
        end else if (dec_addr == IO_UART_STAT) begin
            io_rdata[STAT_TX_FULL]     = io_buffer_full;
            io_rdata[STAT_RX_NONEMPTY] = rx_nonempty;
        end
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (rdy && !io && mem_wr) ram[ram_addr] <= mem_dout;
    end

    // Registered read data; holds during writes and while rdy is low.
    always_ff @(posedge clk) begin
        if (rst)                 mem_din <= 8'h00;
        else if (rdy && !mem_wr) mem_din <= io ? io_rdata : ram[ram_addr];
    end

    // Backpressure flag tracks the post-update TX occupancy, pops included.
    always_ff @(posedge clk) begin
        if (rst) io_buffer_full <= 1'b0;
        else     io_buffer_full <= (tx_count_next >= TX_CW'(TX_DEPTH - 2));
    end

    // Sticky flags: dropped TX push and program end.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_overflow <= 1'b0;
            halt        <= 1'b0;
        end else begin
            if (tx_push && tx_full && !tx_pop) tx_overflow <= 1'b1;
            if (rdy && io && mem_wr && (dec_addr == IO_UART_STAT)) halt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder (default parameters).
// Sections guarded by MEMRESP_RX_EN follow the RTL build of the RX path.
module tb_mem_io_responder;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        halt;

    int checks   = 0;
    int failures = 0;

    mem_io_responder dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .halt           (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        mem_a = a; mem_wr = 1'b1; mem_dout = d;
        tick();
        mem_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        mem_a = a; mem_wr = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; mem_a = '0; mem_wr = 1'b0; mem_dout = '0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        tick(); tick();
        check("rst_mem_din", mem_din, 8'h00);
        check("rst_halt", halt, 1'b0);
        check("rst_full", io_buffer_full, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        rst = 1'b0;

        // RAM writes, mem_din must hold at 0 through them
        for (int i = 0; i < 4; i++) begin
            bus_write(32'h100 + i, 8'h11 * (i + 1));
            check($sformatf("wr_hold_%0d", i), mem_din, 8'h00);
        end
        // Back-to-back reads, upper address bits must be ignored
        bus_read(32'hFFFC_0100); check("rd_100", mem_din, 8'h11);
        bus_read(32'h0000_0101); check("rd_101", mem_din, 8'h22);
        bus_read(32'h0000_0102); check("rd_102", mem_din, 8'h33);
        bus_read(32'h0000_0103); check("rd_103", mem_din, 8'h44);

        // Read immediately after write
        bus_write(32'h200, 8'hAB);
        check("wr_200_hold", mem_din, 8'h44);
        bus_read(32'h200); check("rd_after_wr", mem_din, 8'hAB);

        // IO reads on an idle block
        bus_read(32'h30004); check("stat_idle", mem_din, 8'h00);
        bus_read(32'h30000); check("data_idle", mem_din, 8'h00);
        bus_read(32'h30006); check("io_other_rd", mem_din, 8'h00);

        // Fill TX with the sink stalled; 9th push is dropped
        for (int k = 1; k <= 9; k++) begin
            bus_write(32'h30000, 8'hA0 + 8'(k - 1));
            check($sformatf("tx_full_after_%0d", k), io_buffer_full, (k >= 6) ? 1'b1 : 1'b0);
            check($sformatf("tx_head_after_%0d", k), tx_data, 8'hA0);
        end
        check("tx_overflow_set", dut.tx_overflow, 1'b1);
        bus_read(32'h30004); check("stat_full", mem_din, 8'h01);

        // Drain: exactly the first eight bytes, in order
        mem_a = 32'h100;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_valid_%0d", i), tx_valid, 1'b1);
            check($sformatf("drain_data_%0d", i), tx_data, 8'hA0 + 8'(i));
            tick();
        end
        check("drain_empty", tx_valid, 1'b0);
        check("drain_full_clr", io_buffer_full, 1'b0);
        tx_ready = 1'b0;

        // rdy low freezes RAM writes, TX pushes and mem_din
        bus_read(32'h200); check("pre_freeze", mem_din, 8'hAB);
        rdy = 1'b0;
        bus_write(32'h200, 8'h55); check("frz_wr_hold", mem_din, 8'hAB);
        bus_write(32'h30000, 8'h77); check("frz_no_push", tx_valid, 1'b0);
        bus_read(32'h100); check("frz_rd_hold", mem_din, 8'hAB);
        bus_write(32'h30004, 8'h00); check("frz_no_halt", halt, 1'b0);
        rdy = 1'b1;
        bus_read(32'h200); check("frz_ram_kept", mem_din, 8'hAB);

        // TX pop still runs with rdy low
        bus_write(32'h30000, 8'h3C);
        check("pop_frz_pushed", tx_valid, 1'b1);
        check("pop_frz_data", tx_data, 8'h3C);
        rdy = 1'b0; tx_ready = 1'b1;
        tick();
        check("pop_frz_popped", tx_valid, 1'b0);
        rdy = 1'b1; tx_ready = 1'b0;

        // Non-decoded IO write is ignored
        bus_write(32'h30002, 8'h99);
        check("io_other_wr", tx_valid, 1'b0);
        check("io_other_halt", halt, 1'b0);

        // Halt is sticky
        bus_write(32'h30004, 8'h00); check("halt_set", halt, 1'b1);
        bus_read(32'h100); check("halt_hold_rd", halt, 1'b1);
        check("halt_rd_data", mem_din, 8'h11);
        bus_write(32'h300, 8'h01); check("halt_hold_wr", halt, 1'b1);

        // Reset mid-stream with TX occupied and overflow recorded
        for (int i = 0; i < 9; i++) bus_write(32'h30000, 8'(i));
        check("pre_rst_ovf", dut.tx_overflow, 1'b1);
        check("pre_rst_full", io_buffer_full, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_tx_valid", tx_valid, 1'b0);
        check("mid_rst_mem_din", mem_din, 8'h00);
        check("mid_rst_halt", halt, 1'b0);
        check("mid_rst_full", io_buffer_full, 1'b0);
        check("mid_rst_ovf", dut.tx_overflow, 1'b0);
        bus_read(32'h101); check("ram_survives_rst", mem_din, 8'h22);

        // RX path
        rx_data = 8'h5A; rx_valid = 1'b1; tick();
        rx_data = 8'h5B; tick();
        rx_valid = 1'b0;
`ifdef MEMRESP_RX_EN
        bus_read(32'h30004); check("rx_stat_ne", mem_din, 8'h02);
        bus_read(32'h30000); check("rx_pop_0", mem_din, 8'h5A);
        bus_read(32'h30000); check("rx_pop_1", mem_din, 8'h5B);
        bus_read(32'h30000); check("rx_pop_empty", mem_din, 8'h00);
        bus_read(32'h30004); check("rx_stat_empty", mem_din, 8'h00);
`else
        bus_read(32'h30004); check("rx_off_stat", mem_din, 8'h00);
        bus_read(32'h101);   check("rx_off_pre", mem_din, 8'h22);
        bus_read(32'h30000); check("rx_off_data", mem_din, 8'h00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
